// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared constants and types for the OSPFB sequencer: FSM state encoding,
// FFT config word width and a saturating counter helper.
`timescale 1ns/1ps
package alpaca_ospfb_constants_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        CONFIG  = 3'd2,
        WAITFFT = 3'd3,
        RUN     = 3'd4,
        RECOVER = 3'd5
    } ospfb_seq_state_t;

    localparam int FFT_CONF_WID = 8;
    localparam int EVT_CNT_WID  = 16;
    localparam logic [EVT_CNT_WID-1:0] EVT_CNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [EVT_CNT_WID-1:0] sat_inc(
        input logic [EVT_CNT_WID-1:0] val,
        input logic                   inc
    );
        if (inc && (val != EVT_CNT_MAX)) begin
            return val + 1'b1;
        end
        return val;
    endfunction

endpackage

// File: rtl/ospfb_phase_acc.sv
// Frame phase accumulator: advances by STEP modulo 2**W once per completed
// frame and supplies the rotation index for the phase-comp buffer.
`timescale 1ns/1ps
module ospfb_phase_acc #(
    parameter int W    = 6,
    parameter int STEP = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         step_en,
    output logic [W-1:0] phase
);

    localparam logic [W-1:0] STEP_W = W'(STEP);

    // clr wins over step_en so a resync on a wrap beat still lands on zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (step_en) begin
            phase <= phase + STEP_W;
        end
    end

endmodule

// File: rtl/ospfb_seq_ctrl.sv
// OSPFB start-up/run-time sequencer: FIR flush, FFT config, frame gating,
// tlast and phase rotation, resync on framing errors.
// Optional event statistics are built when OSPFB_SEQ_STATS_EN is defined.
`timescale 1ns/1ps
module ospfb_seq_ctrl
    import alpaca_ospfb_constants_pkg::*;
#(
    parameter int FFT_LEN  = 64,
    parameter int DEC_FAC  = 48,
    parameter int PTAPS    = 8,
    parameter int CONF_WID = FFT_CONF_WID,
    parameter int FFT_CONF = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    output logic                        hold_rst,
    output logic [CONF_WID-1:0]         m_axis_fft_config_tdata,
    output logic                        m_axis_fft_config_tvalid,
    input  logic                        m_axis_fft_config_tready,
    input  logic                        fft_s_tready,
    input  logic                        src_tvalid,
    output logic                        src_tready,
    output logic                        fft_tlast,
    output logic [$clog2(FFT_LEN)-1:0]  pha_idx,
    input  logic                        event_tlast_unexpected,
    input  logic                        event_tlast_missing,
    input  logic                        event_fft_overflow,
    input  logic                        event_data_in_channel_halt,
    output logic [2:0]                  state,
    output logic                        resync,
    output logic [15:0]                 ovf_cnt,
    output logic [15:0]                 err_cnt,
    output logic [15:0]                 halt_cnt
);

    localparam int PW        = $clog2(FFT_LEN);
    localparam int FLUSH_CYC = FFT_LEN * PTAPS;
    localparam int FW        = $clog2(FLUSH_CYC);

    localparam logic [PW-1:0] SAMP_LAST  = PW'(FFT_LEN - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    ospfb_seq_state_t cur_st, nxt_st;

    logic [FW-1:0] flush_ctr;
    logic [PW-1:0] samp_ctr;
    logic          beat;
    logic          last_beat;
    logic          frame_err;
    logic          flush_done;
    logic          acc_clr;

    // Handshakes: a source beat is src_tvalid & src_tready, the config word
    // transfers on tvalid & tready; tvalid/tdata never change while waiting.
    assign frame_err  = event_tlast_unexpected | event_tlast_missing;
    assign flush_done = (flush_ctr == FLUSH_LAST);
    assign beat       = src_tvalid & src_tready;
    assign last_beat  = beat & (samp_ctr == SAMP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        unique case (cur_st)
            IDLE: begin
                if (en) nxt_st = FLUSH;
            end
            FLUSH: begin
                if (flush_done) nxt_st = CONFIG;
            end
            CONFIG: begin
                if (m_axis_fft_config_tready) nxt_st = WAITFFT;
            end
            WAITFFT: begin
                if (fft_s_tready) nxt_st = RUN;
            end
            RUN: begin
                // Framing errors outrank a stop request; a stop only lands on
                // a frame boundary (tlast beat, or idle at sample zero).
                if (frame_err) begin
                    nxt_st = RECOVER;
                end else if (!en && (last_beat || ((samp_ctr == '0) && !beat))) begin
                    nxt_st = IDLE;
                end
            end
            RECOVER: begin
                nxt_st = FLUSH;
            end
            default: begin
                nxt_st = IDLE;
            end
        endcase
    end

    assign state                    = cur_st;
    assign hold_rst                 = (cur_st == IDLE) || (cur_st == FLUSH) || (cur_st == RECOVER);
    assign m_axis_fft_config_tvalid = (cur_st == CONFIG);
    assign m_axis_fft_config_tdata  = CONF_WID'(FFT_CONF);
    assign src_tready               = (cur_st == RUN) & fft_s_tready;
    assign fft_tlast                = last_beat;
    assign resync                   = (cur_st == RECOVER);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_ctr <= '0;
        end else if ((cur_st == FLUSH) && !flush_done) begin
            flush_ctr <= flush_ctr + 1'b1;
        end else begin
            flush_ctr <= '0;
        end
    end

    // Sample index within the frame; FFT_LEN is a power of two so it wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_ctr <= '0;
        end else if ((cur_st != RUN) || frame_err) begin
            samp_ctr <= '0;
        end else if (beat) begin
            samp_ctr <= samp_ctr + 1'b1;
        end
    end

    assign acc_clr = (cur_st == RECOVER) || ((cur_st == RUN) && frame_err);

    ospfb_phase_acc #(
        .W    (PW),
        .STEP (DEC_FAC)
    ) u_phase_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .step_en (last_beat),
        .phase   (pha_idx)
    );

`ifdef OSPFB_SEQ_STATS_EN
    logic [15:0] ovf_q, err_q, halt_q;

    // Events are counted in every state; only frame_err steers the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= '0;
            err_q  <= '0;
            halt_q <= '0;
        end else begin
            ovf_q  <= sat_inc(ovf_q, event_fft_overflow);
            err_q  <= sat_inc(err_q, frame_err);
            halt_q <= sat_inc(halt_q, event_data_in_channel_halt);
        end
    end

    assign ovf_cnt  = ovf_q;
    assign err_cnt  = err_q;
    assign halt_cnt = halt_q;
`else
    logic unused_evt;
    assign unused_evt = event_fft_overflow ^ event_data_in_channel_halt;

    assign ovf_cnt  = 16'd0;
    assign err_cnt  = 16'd0;
    assign halt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ospfb_seq_ctrl.sv
// Directed + randomized bench for ospfb_seq_ctrl with a frame/beat reference model.
`timescale 1ns/1ps
module tb_ospfb_seq_ctrl;

    localparam int M      = 64;
    localparam int D      = 48;
    localparam int TAPS   = 8;
    localparam int FLUSHN = M * TAPS;
`ifdef OSPFB_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, cfg_tready, fft_s_tready, src_tvalid;
    logic        ev_unexp, ev_miss, ev_ovf, ev_halt;
    logic        hold_rst, cfg_tvalid, src_tready, fft_tlast, resync;
    logic [7:0]  cfg_tdata;
    logic [5:0]  pha_idx;
    logic [2:0]  state;
    logic [15:0] ovf_cnt, err_cnt, halt_cnt;

    int checks = 0;
    int errors = 0;
    int samp_n, frames, exp_ovf, exp_err, exp_halt;

    always #5 clk = ~clk;

    ospfb_seq_ctrl #(
        .FFT_LEN (M),
        .DEC_FAC (D),
        .PTAPS   (TAPS)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .en                         (en),
        .hold_rst                   (hold_rst),
        .m_axis_fft_config_tdata    (cfg_tdata),
        .m_axis_fft_config_tvalid   (cfg_tvalid),
        .m_axis_fft_config_tready   (cfg_tready),
        .fft_s_tready               (fft_s_tready),
        .src_tvalid                 (src_tvalid),
        .src_tready                 (src_tready),
        .fft_tlast                  (fft_tlast),
        .pha_idx                    (pha_idx),
        .event_tlast_unexpected     (ev_unexp),
        .event_tlast_missing        (ev_miss),
        .event_fft_overflow         (ev_ovf),
        .event_data_in_channel_halt (ev_halt),
        .state                      (state),
        .resync                     (resync),
        .ovf_cnt                    (ovf_cnt),
        .err_cnt                    (err_cnt),
        .halt_cnt                   (halt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_state",  32'(state), 32'(0));
        chk("rst_hold",   32'(hold_rst), 32'(1));
        chk("rst_tvalid", 32'(cfg_tvalid), 32'(0));
        chk("rst_srdy",   32'(src_tready), 32'(0));
        chk("rst_tlast",  32'(fft_tlast), 32'(0));
        chk("rst_pha",    32'(pha_idx), 32'(0));
        chk("rst_resync", 32'(resync), 32'(0));
        chk("rst_ovf",    32'(ovf_cnt), 32'(0));
        chk("rst_err",    32'(err_cnt), 32'(0));
        chk("rst_halt",   32'(halt_cnt), 32'(0));
    endtask

    // One RUN cycle: expected tlast/pha come from beat and frame counts.
    task automatic run_cycle(input logic v, input logic r, input logic [3:0] ev);
        logic b;
        @(posedge clk); #1;
        src_tvalid = v;
        fft_s_tready = r;
        {ev_unexp, ev_miss, ev_ovf, ev_halt} = ev;
        @(negedge clk);
        b = v & r;
        chk("run_state", 32'(state), 32'(4));
        chk("src_tready", 32'(src_tready), 32'(r));
        chk("pha_idx", 32'(pha_idx), 32'((frames * D) % M));
        chk("fft_tlast", 32'(fft_tlast), 32'(b && (samp_n == M - 1)));
        if (ev[3] | ev[2]) exp_err++;
        if (ev[1]) exp_ovf++;
        if (ev[0]) exp_halt++;
        if (b) begin
            if (samp_n == M - 1) begin
                samp_n = 0;
                frames++;
            end else begin
                samp_n++;
            end
        end
    endtask

    task automatic flush_and_config();
        int cnt = 0;
        bit hold_ok = 1'b1;
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FLUSHN && !seen; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (state == 3'd1) begin
                cnt++;
                if (hold_rst !== 1'b1) hold_ok = 1'b0;
            end
            if (cfg_tvalid === 1'b1) seen = 1'b1;
        end
        chk("flush_len", 32'(cnt), 32'(FLUSHN));
        chk("flush_hold", 32'(hold_ok), 32'(1));
        chk("cfg_tvalid", 32'(seen), 32'(1));
        chk("cfg_tdata", 32'(cfg_tdata), 32'h01);
        chk("cfg_state", 32'(state), 32'(2));
        chk("cfg_hold", 32'(hold_rst), 32'(0));
    endtask

    task automatic config_handshake(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            cfg_tready = 1'b0;
            @(negedge clk);
            chk("stall_tvalid", 32'(cfg_tvalid), 32'(1));
            chk("stall_tdata", 32'(cfg_tdata), 32'h01);
            chk("stall_state", 32'(state), 32'(2));
        end
        @(posedge clk); #1;
        cfg_tready = 1'b1;
        @(negedge clk);
        chk("hs_state", 32'(state), 32'(2));
        @(posedge clk); #1;
        cfg_tready = 1'b0;
        fft_s_tready = 1'b0;
        src_tvalid = 1'b1;
        @(negedge clk);
        chk("wait_state", 32'(state), 32'(3));
        chk("wait_tvalid", 32'(cfg_tvalid), 32'(0));
        chk("wait_srdy", 32'(src_tready), 32'(0));
        @(posedge clk); #1;
        fft_s_tready = 1'b1;
        @(negedge clk);
        chk("wait_rdy_state", 32'(state), 32'(3));
        chk("wait_rdy_srdy", 32'(src_tready), 32'(0));
    endtask

    initial begin
        int guard;
        int f0;
        rst_n = 1'b0; en = 1'b0; cfg_tready = 1'b0; fft_s_tready = 1'b0; src_tvalid = 1'b0;
        ev_unexp = 1'b0; ev_miss = 1'b0; ev_ovf = 1'b0; ev_halt = 1'b0;
        samp_n = 0; frames = 0; exp_ovf = 0; exp_err = 0; exp_halt = 0;

        // Reset and start-up: flush, config with 5-cycle stall, wait for FFT.
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_en", 32'(state), 32'(0));
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        chk("idle_en", 32'(state), 32'(0));
        flush_and_config();
        config_handshake(5);

        // Continuous stream: five frames, phase sequence 0,48,32,16,0.
        for (int i = 0; i < 5 * M; i++) run_cycle(1'b1, 1'b1, 4'b0000);

        // Random back-pressure with occasional non-fatal events.
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      {2'b00, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0)});
        end

        // Framing error at beat 20 of a frame.
        guard = 0;
        while (samp_n != 20 && guard < 2000) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'b0000);
            guard++;
        end
        chk("reach_beat20", 32'(samp_n), 32'(20));
        run_cycle(1'b1, 1'b1, 4'b0100);
        @(posedge clk); #1;
        ev_miss = 1'b0;
        @(negedge clk);
        chk("rec_state", 32'(state), 32'(5));
        chk("rec_resync", 32'(resync), 32'(1));
        chk("rec_pha", 32'(pha_idx), 32'(0));
        chk("rec_srdy", 32'(src_tready), 32'(0));
        chk("rec_hold", 32'(hold_rst), 32'(1));
        samp_n = 0;
        frames = 0;
        flush_and_config();
        chk("rec_err_cnt", 32'(err_cnt), STATS ? 32'(exp_err) : 32'(0));
        config_handshake(0);

        // Stop request at beat 10: frame completes, then IDLE.
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b1, 4'b0000);
        en = 1'b0;
        f0 = frames;
        guard = 0;
        while (frames == f0 && guard < 2000) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'b0000);
            guard++;
        end
        chk("stop_frame_done", 32'(frames), 32'(f0 + 1));
        @(posedge clk); #1;
        src_tvalid = 1'b1;
        fft_s_tready = 1'b1;
        @(negedge clk);
        chk("stop_state", 32'(state), 32'(0));
        chk("stop_srdy", 32'(src_tready), 32'(0));
        chk("stop_hold", 32'(hold_rst), 32'(1));
        chk("stop_tlast", 32'(fft_tlast), 32'(0));

        // Framing event outside RUN is counted but does not move the FSM.
        @(posedge clk); #1;
        ev_unexp = 1'b1;
        @(negedge clk);
        exp_err++;
        @(posedge clk); #1;
        ev_unexp = 1'b0;
        @(negedge clk);
        chk("idle_evt_state", 32'(state), 32'(0));
        chk("idle_evt_resync", 32'(resync), 32'(0));
        chk("err_cnt", 32'(err_cnt), STATS ? 32'(exp_err) : 32'(0));
        chk("ovf_cnt", 32'(ovf_cnt), STATS ? 32'(exp_ovf) : 32'(0));
        chk("halt_cnt", 32'(halt_cnt), STATS ? 32'(exp_halt) : 32'(0));

        // Restart keeps the phase; then reset mid-RUN.
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        flush_and_config();
        config_handshake(0);
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b1, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
